// File: rtl/h2c_axis_upsizer.sv
// 64-to-128-bit AXI-Stream upsizer for the XDMA H2C path: packs beat pairs, keeps packet
// boundaries, buffers words in a small output FIFO and exposes packet/keep-error debug status.
module h2c_axis_upsizer #(
    parameter int unsigned OUT_DEPTH = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [127:0]     m_axis_tdata,
    output logic [15:0]      m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             keep_err
);
    localparam int unsigned PW = $clog2(OUT_DEPTH);
    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic {LOW, HIGH} state_t;

    state_t           state_q;
    logic [63:0]      low_data_q;
    logic [7:0]       low_keep_q;
    logic [127:0]     mem_data_q [OUT_DEPTH];
    logic [15:0]      mem_keep_q [OUT_DEPTH];
    logic             mem_last_q [OUT_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] pkt_cnt_q;
    logic             keep_err_q;

    logic             in_fire, pop, push, push_last, keep_bad;
    logic [127:0]     push_data;
    logic [15:0]      push_keep;

    assign in_fire = s_axis_tvalid && s_axis_tready;
    assign pop     = m_axis_tvalid && m_axis_tready;

    // A last beat's keep is contiguous from bit 0 exactly when keep & (keep+1) is zero.
    assign keep_bad = in_fire && (s_axis_tlast ? |(s_axis_tkeep & (s_axis_tkeep + 8'd1))
                                                : (s_axis_tkeep != 8'hFF));

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        push_keep = '0;
        push_last = 1'b0;
        if (in_fire) begin
            if (state_q == HIGH) begin
                push      = 1'b1;
                push_data = {s_axis_tdata, low_data_q};
                push_keep = {s_axis_tkeep, low_keep_q};
                push_last = s_axis_tlast;
            end else if (s_axis_tlast) begin
                push      = 1'b1;
                push_data = {64'h0, s_axis_tdata};
                push_keep = {8'h00, s_axis_tkeep};
                push_last = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= push_data;
            mem_keep_q[wr_ptr_q] <= push_keep;
            mem_last_q[wr_ptr_q] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOW;
            low_data_q <= '0;
            low_keep_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_cnt_q  <= '0;
            keep_err_q <= 1'b0;
        end else begin
            keep_err_q <= keep_bad;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (pop && m_axis_tlast) begin
                pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
            if (in_fire) begin
                if (state_q == LOW) begin
                    if (!s_axis_tlast) begin
                        low_data_q <= s_axis_tdata;
                        low_keep_q <= s_axis_tkeep;
                        state_q    <= HIGH;
                    end
                end else begin
                    state_q <= LOW;
                end
            end
        end
    end

    // Ready comes only from the registered occupancy, so no input-to-output combinational path.
    assign s_axis_tready = !rst && (count_q < CW'(OUT_DEPTH));
    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_data_q[rd_ptr_q] : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? mem_keep_q[rd_ptr_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid ? mem_last_q[rd_ptr_q] : 1'b0;
    assign pkt_cnt       = pkt_cnt_q;
    assign keep_err      = keep_err_q;

endmodule

// File: doc/h2c_axis_upsizer.md
# h2c_axis_upsizer

AXI-Stream width upsizer between the XDMA H2C channel 0 master port (64-bit) and the inbound controller, which consumes 128-bit words. It packs pairs of 64-bit beats into one 128-bit beat and preserves packet boundaries, so a packet with an odd number of beats ends in a half-filled word. A small output FIFO absorbs consumer stalls. It also provides a packet counter and a keep-error pulse for debug readout over JTAG.

## Interface
Parameters:
- OUT_DEPTH, 2: output FIFO depth in 128-bit entries; power of two, 2 or more.
- CNT_W, 16: width of pkt_cnt.

Ports:
- clk  in  1  single clock, driven from axi_aclk.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  64  H2C data.
- s_axis_tkeep  in  8  byte enables.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  128  packed data; the first 64-bit beat is in [63:0].
- m_axis_tkeep  out  16  packed byte enables.
- m_axis_tlast  out  1  last word of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- pkt_cnt  out  CNT_W  count of packets delivered downstream.
- keep_err  out  1  one-cycle pulse on a malformed tkeep.

## Operation
- Input transfer: s_axis_tvalid && s_axis_tready. Output transfer: m_axis_tvalid && m_axis_tready.
- Packer state machine:
  - State LOW, initial state:
    - Non-last beat: latch tdata/tkeep into the low-half register and go to HIGH.
    - Last beat: push {64'h0, tdata} with keep {8'h00, tkeep} and last=1, then stay in LOW.
  - State HIGH:
    - Any beat: push {tdata, low_data} with keep {tkeep, low_keep} and last=tlast, then go to LOW.
- A push writes the output FIFO. The FIFO head drives the m_axis_* signals.
- s_axis_tready = (fifo_count < OUT_DEPTH) && !rst.
  - Registered from state, not derived from m_axis_tready or s_axis_tvalid. No combinational path from input to output.
  - In LOW, a non-last beat needs no FIFO space. The team still gates it with the same ready signal, for simplicity.
- Simultaneous push and pop when full cannot occur, because ready was low. When count == OUT_DEPTH-1, push and pop in the same cycle leave the count unchanged.
- tkeep rules:
  - A non-last beat must have tkeep = 8'hFF.
  - A last beat must be contiguous from bit 0 (8'h01, 03, 07, ... FF) or 8'h00.
  - Any violation pulses keep_err for one cycle, the cycle after the transfer. The data is still forwarded unchanged.
- A last beat with tkeep = 8'h00 in HIGH is legal and gives m_axis_tkeep = 16'h00FF.
- pkt_cnt increments on every output transfer with m_axis_tlast = 1. It wraps from 2^CNT_W-1 to 0.
- Reset, applied at any time including mid-packet:
  - Packer returns to LOW and the FIFO empties. A pending low half is discarded.
  - pkt_cnt clears; keep_err, m_axis_tvalid and s_axis_tready drive 0.
  - m_axis_tdata/tkeep/tlast drive 0.
  - No partial word is emitted after reset.

## Timing
- Reset values of all outputs are 0, including s_axis_tready. s_axis_tready rises in the first cycle after rst is deasserted.
- Latency: m_axis_tvalid rises one cycle after the input transfer that completes a word, with an empty FIFO.
- Throughput: one 64-bit input beat per cycle sustained. Equivalently, one 128-bit word every 2 cycles while m_axis_tready stays high.
- Once asserted, m_axis_tvalid holds and m_axis_* stay stable until the output transfer (AXIS rule).
- Full stall: with m_axis_tready low, s_axis_tready falls in the cycle after the OUT_DEPTH-th push. It rises in the cycle after the first pop.
- keep_err and the pkt_cnt update are both registered, one cycle after their triggering transfer.

## Test plan
- Four-beat packet (A0..A3, tkeep FF, tlast on A3), m_axis_tready=1 -> two words: {A1,A0} keep FFFF last 0; {A3,A2} keep FFFF last 1. pkt_cnt goes to 1.
- Three-beat packet, last tkeep=8'h0F -> words {B1,B0} FFFF last 0; {0,B2} 000F last 1. The packer is back in LOW.
- m_axis_tready held 0, continuous input at OUT_DEPTH=2 -> s_axis_tready low after 4 input beats (2 words). Releasing tready drains the FIFO in order with no lost or duplicated words.
- Non-last beat with tkeep=8'h7F -> keep_err high exactly 1 cycle and the data is forwarded. Last tkeep=8'h05 also raises keep_err. Last tkeep=8'h00 in HIGH -> keep 00FF with no error.
- rst asserted while in HIGH with a full FIFO -> the next cycle shows all outputs 0. A following 2-beat packet outputs a single correct word with no stale data.
- With CNT_W=4, send 17 one-beat packets -> pkt_cnt reads 1 after the wrap.
